// File: rtl/sumador_pipe.sv
// sumador_pipe: two-stage pipelined unsigned add/subtract/accumulate core with valid handshake and global stall.
// Define SUMADOR_PIPE_SAT_EN to saturate overflowing results instead of wrapping.
module sumador_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic             VALID_IN,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             RCI,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             VALID_OUT
);
  logic             s1_valid_q;
  logic [1:0]       s1_modo_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s1_rci_q;
  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic             valid_out_q;
  logic [WIDTH:0]   rci_x, add_r, sub_r, acc_r, res;
  // Bit WIDTH of every result is the carry, or the borrow for subtraction.
  always_comb begin
    rci_x = {{WIDTH{1'b0}}, s1_rci_q};
    add_r = {1'b0, s1_a_q} + {1'b0, s1_b_q} + rci_x;
    sub_r = {1'b0, s1_a_q} - {1'b0, s1_b_q} - rci_x;
    acc_r = {1'b0, q_q} + {1'b0, s1_a_q} + rci_x;
    res   = s1_modo_q == 2'b00 ? '0 : s1_modo_q == 2'b01 ? add_r : s1_modo_q == 2'b10 ? sub_r : acc_r;
    rco_d = res[WIDTH];
`ifdef SUMADOR_PIPE_SAT_EN
    q_d   = !res[WIDTH] ? res[WIDTH-1:0] : s1_modo_q == 2'b10 ? '0 : '1;
`else
    q_d   = res[WIDTH-1:0];
`endif
  end
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      s1_valid_q  <= 1'b0;
      s1_modo_q   <= 2'b00;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_rci_q    <= 1'b0;
      q_q         <= '0;
      rco_q       <= 1'b0;
      valid_out_q <= 1'b0;
    end else if (ENB) begin
      s1_valid_q  <= VALID_IN;
      s1_modo_q   <= MODO;
      s1_a_q      <= A;
      s1_b_q      <= B;
      s1_rci_q    <= RCI;
      valid_out_q <= s1_valid_q;
      if (s1_valid_q) begin
        q_q   <= q_d;
        rco_q <= rco_d;
      end
    end
  end
  assign Q         = q_q;
  assign RCO       = rco_q;
  assign VALID_OUT = valid_out_q;
endmodule

// File: tb/tb_sumador_pipe.sv
// tb_sumador_pipe: vector table, hand sequences and randomized run against an arithmetic reference model.
module tb_sumador_pipe;
`ifdef SUMADOR_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic        CLK = 1'b0;
  logic        RESET_L = 1'b0;
  logic        ENB = 1'b0;
  logic        VALID_IN = 1'b0;
  logic [1:0]  MODO = 2'b00;
  logic [7:0]  A = '0, B = '0;
  logic        RCI = 1'b0;
  logic [7:0]  Q;
  logic        RCO, VALID_OUT;
  logic        w_valid = 1'b0;
  logic [31:0] w_a = '0, w_b = '0;
  logic [31:0] w_q;
  logic        w_rco, w_vout;
  int total = 0;
  int bad = 0;

  typedef struct {
    bit   v;
    logic [1:0] m;
    int   a, b, r;
  } rq_t;

  typedef struct {
    logic [1:0] m;
    int   a, b, r;
    int   q_wrap, q_sat;
    bit   rco;
  } vec_t;

  rq_t pipe[$];
  int  exp_q;
  bit  exp_rco, exp_v;

  sumador_pipe #(.WIDTH(8)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .VALID_IN(VALID_IN), .MODO(MODO),
    .A(A), .B(B), .RCI(RCI), .Q(Q), .RCO(RCO), .VALID_OUT(VALID_OUT)
  );

  sumador_pipe #(.WIDTH(32)) dut_w (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .VALID_IN(w_valid), .MODO(2'b01),
    .A(w_a), .B(w_b), .RCI(1'b0), .Q(w_q), .RCO(w_rco), .VALID_OUT(w_vout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
    end
  endtask

  // Reference result as plain unsigned integer arithmetic on 8-bit values.
  function automatic void ref_op(input rq_t r, input int prev, output int q, output bit c);
    int s;
    case (r.m)
      2'b00: begin s = 0; c = 1'b0; end
      2'b01: begin s = r.a + r.b + r.r; c = s > 255; s = (SAT && c) ? 255 : s % 256; end
      2'b10: begin c = r.a < r.b + r.r; s = (SAT && c) ? 0 : (r.a - r.b - r.r + 512) % 256; end
      default: begin s = prev + r.a + r.r; c = s > 255; s = (SAT && c) ? 255 : s % 256; end
    endcase
    q = s;
  endfunction

  task automatic model_reset();
    rq_t idle;
    idle = '{v: 1'b0, m: 2'b00, a: 0, b: 0, r: 0};
    pipe = {idle};
    exp_q = 0;
    exp_rco = 1'b0;
    exp_v = 1'b0;
  endtask

  task automatic step(input bit e, input bit v, input logic [1:0] m, input int a, input int b, input int r);
    rq_t cur, old;
    int q;
    bit c;
    ENB = e;
    VALID_IN = v;
    MODO = m;
    A = a[7:0];
    B = b[7:0];
    RCI = r[0];
    @(posedge CLK);
    if (e) begin
      cur = '{v: v, m: m, a: a, b: b, r: r};
      old = pipe.pop_front();
      pipe.push_back(cur);
      exp_v = old.v;
      if (old.v) begin
        ref_op(old, exp_q, q, c);
        exp_q = q;
        exp_rco = c;
      end
    end
    #1;
  endtask

  task automatic chk_out(input string n, input int q, input bit c, input bit v);
    chk({n, ".Q"}, {24'h0, Q}, q);
    chk({n, ".RCO"}, {31'h0, RCO}, {31'h0, c});
    chk({n, ".VALID_OUT"}, {31'h0, VALID_OUT}, {31'h0, v});
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{2'b01, 'hF0, 'h20, 1, 'h11, 'hFF, 1'b1};
    vt[1] = '{2'b10, 'h05, 'h07, 0, 'hFE, 'h00, 1'b1};
    vt[2] = '{2'b10, 'h07, 'h05, 0, 'h02, 'h02, 1'b0};
    vt[3] = '{2'b01, 'h01, 'h02, 0, 'h03, 'h03, 1'b0};
    vt[4] = '{2'b00, 'h55, 'hAA, 1, 'h00, 'h00, 1'b0};
    vt[5] = '{2'b11, 'h10, 'hEE, 1, 'h11, 'h11, 1'b0};
    vt[6] = '{2'b11, 'hF0, 'h00, 0, 'h01, 'hFF, 1'b1};
    vt[7] = '{2'b10, 'h00, 'hFF, 1, 'h00, 'h00, 1'b1};
    vt[8] = '{2'b01, 'hFF, 'h00, 1, 'h00, 'hFF, 1'b1};
    vt[9] = '{2'b10, 'h10, 'h0F, 1, 'h00, 'h00, 1'b0};
    model_reset();
    #2;
    chk_out("reset", 0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    RESET_L = 1'b1;
    foreach (vt[i]) begin
      step(1, 1, vt[i].m, vt[i].a, vt[i].b, vt[i].r);
      step(1, 0, 2'b00, 0, 0, 0);
      chk_out($sformatf("vec%0d", i), SAT ? vt[i].q_sat : vt[i].q_wrap, vt[i].rco, 1'b1);
      step(1, 0, 2'b00, 0, 0, 0);
      chk({$sformatf("vec%0d", i), ".pulse"}, {31'h0, VALID_OUT}, 32'h0);
    end
    step(1, 1, 2'b00, 0, 0, 0);
    step(1, 1, 2'b11, 'h10, 0, 0);
    chk_out("chain0", 'h00, 1'b0, 1'b1);
    step(1, 1, 2'b11, 'h20, 0, 0);
    chk_out("chain1", 'h10, 1'b0, 1'b1);
    step(1, 1, 2'b11, 'h30, 0, 0);
    chk_out("chain2", 'h30, 1'b0, 1'b1);
    step(1, 0, 2'b00, 0, 0, 0);
    chk_out("chain3", 'h60, 1'b0, 1'b1);
    step(1, 0, 2'b00, 0, 0, 0);
    chk_out("chain_end", 'h60, 1'b0, 1'b0);
    step(1, 1, 2'b01, 'h01, 'h02, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 2'b00, 0, 0, 0);
      chk_out($sformatf("stall%0d", i), 'h60, 1'b0, 1'b0);
    end
    step(1, 0, 2'b00, 0, 0, 0);
    chk_out("stall_res", 'h03, 1'b0, 1'b1);
    step(1, 0, 2'b00, 0, 0, 0);
    chk_out("stall_once", 'h03, 1'b0, 1'b0);
    step(1, 1, 2'b01, 'h40, 'h40, 0);
    RESET_L = 1'b0;
    #1;
    chk_out("midreset", 0, 1'b0, 1'b0);
    model_reset();
    RESET_L = 1'b1;
    step(1, 0, 2'b00, 0, 0, 0);
    chk_out("post_rst0", 0, 1'b0, 1'b0);
    step(1, 0, 2'b00, 0, 0, 0);
    chk_out("post_rst1", 0, 1'b0, 1'b0);
    w_valid = 1'b1;
    w_a = 32'hFFFF_FFFF;
    w_b = 32'h0000_0001;
    step(1, 0, 2'b00, 0, 0, 0);
    w_valid = 1'b0;
    step(1, 0, 2'b00, 0, 0, 0);
    chk("wide.Q", w_q, SAT ? 32'hFFFF_FFFF : 32'h0);
    chk("wide.RCO", {31'h0, w_rco}, 32'h1);
    chk("wide.VALID_OUT", {31'h0, w_vout}, 32'h1);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
      chk_out($sformatf("rnd%0d", i), exp_q, exp_rco, exp_v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
